// File: rtl/retry_end_limited.sv
`default_nettype none
// ============================================================================
// Module   : retry_end_limited
// Brief    : Terminating stage of a time-redundant retry loop. Clean results
//            go downstream; faulty results go back to the retry start until a
//            per-ID retry budget is exhausted, after which they are forwarded
//            downstream with an error flag.
// Options  : RETRY_END_LIMITED_STATS_EN adds saturating retry/exhaustion
//            event counters (retry_cnt_o, exhausted_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
module retry_end_limited #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned IDSize     = 2,
    parameter int unsigned MaxRetries = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // upstream (from redundancy checker)
    input  logic [DataWidth-1:0] data_i,
    input  logic [IDSize-1:0]    id_i,
    input  logic                 faulty_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    // downstream
    output logic [DataWidth-1:0] data_o,
    output logic                 error_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    // retry request back to the loop start
    output logic [IDSize-1:0]    retry_id_o,
    output logic                 retry_valid_o,
    input  logic                 retry_ready_i
`ifdef RETRY_END_LIMITED_STATS_EN
    ,
    output logic [31:0]          retry_cnt_o,
    output logic [31:0]          exhausted_cnt_o
`endif
);

    localparam int unsigned         CntWidth = $clog2(MaxRetries + 1);
    localparam int unsigned         NumIds   = 2 ** IDSize;
    localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxRetries);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CntWidth-1:0]  cnt_q [NumIds];

    logic [DataWidth-1:0] down_data_q, down_data_d;
    logic                 down_err_q,  down_err_d;
    logic                 down_vld_q,  down_vld_d;

    logic [IDSize-1:0]    rty_id_q,    rty_id_d;
    logic                 rty_vld_q,   rty_vld_d;

    // ------------------------------------------------------------------------
    // Route decision and handshake
    // ------------------------------------------------------------------------
    logic route_retry;
    logic route_err;
    logic down_free;
    logic rty_free;
    logic accept;

    // Pick the destination register from the fault flag and this ID's budget.
    always_comb begin
        route_retry = faulty_i && (cnt_q[id_i] < MaxCnt);
        route_err   = faulty_i && !route_retry;
        // A full register counts as free when its consumer takes it this cycle.
        down_free   = !down_vld_q || ready_i;
        rty_free    = !rty_vld_q  || retry_ready_i;
        ready_o     = route_retry ? rty_free : down_free;
        accept      = valid_i && ready_o;
    end

    // Next-state of both output registers: load on accept, else drain.
    always_comb begin
        down_data_d = down_data_q;
        down_err_d  = down_err_q;
        down_vld_d  = down_vld_q;
        rty_id_d    = rty_id_q;
        rty_vld_d   = rty_vld_q;

        if (accept && !route_retry) begin
            down_data_d = data_i;
            down_err_d  = route_err;
            down_vld_d  = 1'b1;
        end else if (ready_i) begin
            down_vld_d  = 1'b0;
        end

        if (accept && route_retry) begin
            rty_id_d    = id_i;
            rty_vld_d   = 1'b1;
        end else if (retry_ready_i) begin
            rty_vld_d   = 1'b0;
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            down_data_q <= '0;
            down_err_q  <= 1'b0;
            down_vld_q  <= 1'b0;
            rty_id_q    <= '0;
            rty_vld_q   <= 1'b0;
        end else begin
            down_data_q <= down_data_d;
            down_err_q  <= down_err_d;
            down_vld_q  <= down_vld_d;
            rty_id_q    <= rty_id_d;
            rty_vld_q   <= rty_vld_d;
        end
    end

    // Per-ID retry counters: bump on an accepted retry, clear on any
    // accepted downstream result. The budget check keeps them <= MaxRetries.
    generate
        for (genvar g = 0; g < NumIds; g++) begin : g_cnt
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q[g] <= '0;
                end else if (accept && (id_i == IDSize'(g))) begin
                    if (route_retry) begin
                        cnt_q[g] <= cnt_q[g] + CntWidth'(1);
                    end else begin
                        cnt_q[g] <= '0;
                    end
                end
            end
        end
    endgenerate

    assign data_o        = down_data_q;
    assign error_o       = down_err_q;
    assign valid_o       = down_vld_q;
    assign retry_id_o    = rty_id_q;
    assign retry_valid_o = rty_vld_q;

`ifdef RETRY_END_LIMITED_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------------
    logic [31:0] stat_rty_q;
    logic [31:0] stat_exh_q;

    // Count accepted retries and accepted exhausted results, stopping at max.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_rty_q <= '0;
            stat_exh_q <= '0;
        end else if (accept) begin
            if (route_retry && (stat_rty_q != 32'hFFFF_FFFF)) begin
                stat_rty_q <= stat_rty_q + 32'd1;
            end
            if (route_err && (stat_exh_q != 32'hFFFF_FFFF)) begin
                stat_exh_q <= stat_exh_q + 32'd1;
            end
        end
    end

    assign retry_cnt_o     = stat_rty_q;
    assign exhausted_cnt_o = stat_exh_q;
`endif

endmodule
`default_nettype wire

// File: doc/retry_end_limited.md
Name: retry_end_limited

Overview:
- Terminating stage of a time-redundant retry loop.
- Receives results tagged with an ID and a fault flag from the redundancy checker.
- Clean results are registered and sent downstream. Faulty results are registered and sent back to the retry start as a retry request.
- A per-ID retry counter bounds retries: once an ID has been retried MaxRetries times, a further fault is forwarded downstream with an error flag instead of retried.

Parameters:
- DataWidth, 32, width of data payload
- IDSize, 2, width of transaction ID; counter table has 2**IDSize entries
- MaxRetries, 3, maximum retries per ID before forwarding with error; must be >= 1
- CntWidth, $clog2(MaxRetries+1), derived localparam, per-ID counter width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- data_i  in  DataWidth  upstream payload
- id_i  in  IDSize  upstream transaction ID
- faulty_i  in  1  upstream result mismatch flag
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  DataWidth  downstream payload
- error_o  out  1  downstream result exhausted retries and is still faulty
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- retry_id_o  out  IDSize  ID to re-issue
- retry_valid_o  out  1  retry request valid
- retry_ready_i  in  1  retry start accepts request

Behaviour:
- One clock domain (clk_i); synchronous active-high reset (rst_i).
- Reset values: valid_o=0, retry_valid_o=0, data_o=0, error_o=0, retry_id_o=0, all counters=0.
- Reset mid-operation discards both registered entries without handshake.
- Route decision (combinational, from current inputs and cnt[id_i]):
  - faulty_i=0 gives DOWN, error=0.
  - faulty_i=1 and cnt[id_i]<MaxRetries gives RETRY.
  - faulty_i=1 and cnt[id_i]==MaxRetries gives DOWN, error=1.
- Two single-entry output registers: down register (data_o, error_o, valid_o) and retry register (retry_id_o, retry_valid_o).
- A register is free when it is empty, or when it is full and its consumer is ready this cycle (pass-through drain, full throughput).
- ready_o = free flag of the register selected by the route decision. It may depend combinationally on faulty_i, id_i, ready_i and retry_ready_i. It must not depend on valid_i.
- Handshake: accept when valid_i and ready_o. The selected register loads on the next edge, so latency is exactly 1 cycle.
- A register whose consumer is ready and that is not reloaded goes empty; its valid drops the next cycle.
- Output valid/data stay stable while valid is high and the consumer is not ready.
- Counter update, on accept only:
  - RETRY: cnt[id_i] += 1.
  - DOWN (either error value): cnt[id_i] = 0.
  - Other entries unchanged. Counters never exceed MaxRetries, so no wrap-around.
- Both registers may drain in the same cycle; an accept loading one register is independent of the other's drain.
- Only one input is accepted per cycle, so there are no simultaneous counter writes.
- Upstream must hold data_i/id_i/faulty_i stable while valid_i && !ready_o. Behaviour is undefined otherwise.

Optional Feature:
- Macro: RETRY_END_LIMITED_STATS_EN.
- When defined, add output ports:
  - retry_cnt_o (32 bits): counts accepted RETRY routes.
  - exhausted_cnt_o (32 bits): counts accepted DOWN routes with error=1.
- Both counters are saturating at 2**32-1, reset to 0 and update on the accept edge.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Clean pass: reset, ready_i=1, send id=1 data=0xA5A5A5A5 faulty=0 → next cycle valid_o=1, data_o=0xA5A5A5A5, error_o=0, retry_valid_o=0, cnt[1]=0.
- Retry then success: id=2 faulty=1 three times (retry_ready_i=1) → retry_valid_o=1 with retry_id_o=2 each time, cnt[2]=1,2,3. Then id=2 faulty=0 → valid_o=1, error_o=0, cnt[2]=0.
- Exhaustion: id=0 faulty=1 four times → first three go to retry port, fourth gives valid_o=1, error_o=1, cnt[0]=0. A following fault on id=0 goes to retry again.
- Backpressure: ready_i=0, send clean id=3 → valid_o=1 held. Second clean input sees ready_o=0. A faulty input in the same state sees ready_o=1 and appears on retry port. Raise ready_i → down entry drains, second clean input accepted in same cycle.
- Per-ID isolation: interleave faults id=1 and id=2 → counters advance independently; exhausting id=1 leaves cnt[2] unchanged.
- Reset mid-operation: both registers full, assert rst_i one cycle → next cycle valid_o=0, retry_valid_o=0, all counters 0. With RETRY_END_LIMITED_STATS_EN, stats read 0.
